// File: rtl/proc_pkg.sv
// proc_pkg: functional-unit select codes and operand width shared by the operand routers and collectors
package proc_pkg;
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] MULT = 2'b01;
  localparam logic [1:0] MULADD = 2'b10;
  localparam int OPERAND_WIDTH = 32;
endpackage

// File: rtl/add_operand_collector_if.sv
// add_operand_collector_if: source operand inputs and paired-operand issue bus of one collector
// stall_count is present only when COLLECTOR_STATS_EN is defined
interface add_operand_collector_if #(
  parameter int WIDTH = proc_pkg::OPERAND_WIDTH,
  parameter int DEPTH = 4
);
  logic [1:0] src1_sel;
  logic [WIDTH-1:0] src1_value;
  logic src1_valid;
  logic src1_ready;
  logic [1:0] src2_sel;
  logic [WIDTH-1:0] src2_value;
  logic src2_valid;
  logic src2_ready;
  logic op_valid;
  logic op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [$clog2(DEPTH):0] fifo_count;
  logic fifo_full;
`ifdef COLLECTOR_STATS_EN
  logic [15:0] stall_count;
`endif
  modport master (
    output src1_sel, src1_value, src1_valid, src2_sel, src2_value, src2_valid, op_ready,
    input src1_ready, src2_ready, op_valid, op_a, op_b, fifo_count, fifo_full
`ifdef COLLECTOR_STATS_EN
    , input stall_count
`endif
  );
  modport slave (
    input src1_sel, src1_value, src1_valid, src2_sel, src2_value, src2_valid, op_ready,
    output src1_ready, src2_ready, op_valid, op_a, op_b, fifo_count, fifo_full
`ifdef COLLECTOR_STATS_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/operand_fifo.sv
// operand_fifo: DEPTH-entry FIFO of operand pairs with a combinational head read
module operand_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic [W-1:0] i_data,
  input  logic i_pop,
  output logic [W-1:0] o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_wr <= r_wr + AW'(i_push);
      r_rd <= r_rd + AW'(i_pop);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_data = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
endmodule

// File: rtl/add_operand_collector.sv
// add_operand_collector: pairs source-1/source-2 operands routed to UNIT_SEL and queues them for issue
// Define COLLECTOR_STATS_EN to add the saturating stall_count statistic
module add_operand_collector
  import proc_pkg::*;
#(
  parameter int WIDTH = OPERAND_WIDTH,
  parameter int DEPTH = 4,
  parameter logic [1:0] UNIT_SEL = ADD
) (
  input logic clk,
  input logic reset,
  add_operand_collector_if.slave bus
);
  logic r_held_a;
  logic r_held_b;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic w_acc_a;
  logic w_acc_b;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic [2*WIDTH-1:0] w_head;
  logic [$clog2(DEPTH):0] w_count;
  // a full FIFO still takes the held pair when the head leaves on the same edge
  always_comb begin
    w_acc_a = bus.src1_valid && bus.src1_sel == UNIT_SEL && !r_held_a;
    w_acc_b = bus.src2_valid && bus.src2_sel == UNIT_SEL && !r_held_b;
    w_pop = !w_empty && bus.op_ready;
    w_push = r_held_a && r_held_b && (!w_full || w_pop);
  end
  always_ff @(posedge clk) begin
    if (w_acc_a) r_a <= bus.src1_value;
    if (w_acc_b) r_b <= bus.src2_value;
    if (reset) begin
      r_held_a <= 1'b0;
      r_held_b <= 1'b0;
    end else begin
      r_held_a <= w_push ? 1'b0 : r_held_a | w_acc_a;
      r_held_b <= w_push ? 1'b0 : r_held_b | w_acc_b;
    end
  end
  operand_fifo #(.W(2 * WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .i_push(w_push),
    .i_data({r_a, r_b}),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_count(w_count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign bus.src1_ready = !r_held_a;
  assign bus.src2_ready = !r_held_b;
  assign bus.op_valid = !w_empty;
  assign bus.op_a = w_head[2*WIDTH-1:WIDTH];
  assign bus.op_b = w_head[WIDTH-1:0];
  assign bus.fifo_count = w_count;
  assign bus.fifo_full = w_full;
`ifdef COLLECTOR_STATS_EN
  logic [15:0] r_stall_count;
  always_ff @(posedge clk) begin
    if (reset) r_stall_count <= '0;
    else if (r_held_a && r_held_b && w_full && !w_pop && r_stall_count != 16'hFFFF)
      r_stall_count <= r_stall_count + 16'd1;
  end
  assign bus.stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_add_operand_collector.sv
// tb_add_operand_collector: directed vectors with hand-computed expectations for the ADD collector
module tb_add_operand_collector;
  import proc_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  add_operand_collector_if #(.WIDTH(32), .DEPTH(4)) bus ();
  add_operand_collector #(.WIDTH(32), .DEPTH(4), .UNIT_SEL(ADD)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send1(input logic [1:0] sel, input logic [31:0] v);
    bus.src1_sel = sel;
    bus.src1_value = v;
    bus.src1_valid = 1'b1;
    tick();
    bus.src1_valid = 1'b0;
  endtask
  task automatic send2(input logic [31:0] v);
    bus.src2_sel = ADD;
    bus.src2_value = v;
    bus.src2_valid = 1'b1;
    tick();
    bus.src2_valid = 1'b0;
  endtask
  task automatic send_both(input logic [31:0] a, input logic [31:0] b);
    bus.src1_sel = ADD;
    bus.src1_value = a;
    bus.src1_valid = 1'b1;
    bus.src2_sel = ADD;
    bus.src2_value = b;
    bus.src2_valid = 1'b1;
    tick();
    bus.src1_valid = 1'b0;
    bus.src2_valid = 1'b0;
  endtask
  initial begin
    bus.src1_sel = ADD;
    bus.src1_value = '0;
    bus.src1_valid = 1'b0;
    bus.src2_sel = ADD;
    bus.src2_value = '0;
    bus.src2_valid = 1'b0;
    bus.op_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_valid", 64'(bus.op_valid), 64'd0);
    check("rst_count", 64'(bus.fifo_count), 64'd0);
    check("rst_full", 64'(bus.fifo_full), 64'd0);
    check("rst_rdy1", 64'(bus.src1_ready), 64'd1);
    check("rst_rdy2", 64'(bus.src2_ready), 64'd1);
    // src1 first, src2 two cycles later
    bus.op_ready = 1'b1;
    send1(ADD, 32'h11);
    check("held_rdy1", 64'(bus.src1_ready), 64'd0);
    check("held_rdy2", 64'(bus.src2_ready), 64'd1);
    tick();
    send2(32'h22);
    check("no_passthru", 64'(bus.op_valid), 64'd0);
    tick();
    check("pair_valid", 64'(bus.op_valid), 64'd1);
    check("pair_a", 64'(bus.op_a), 64'h11);
    check("pair_b", 64'(bus.op_b), 64'h22);
    check("pair_cnt", 64'(bus.fifo_count), 64'd1);
    tick();
    check("popped_cnt", 64'(bus.fifo_count), 64'd0);
    check("popped_valid", 64'(bus.op_valid), 64'd0);
    // non-matching select is ignored
    send1(MULT, 32'h99);
    check("mult_ignored", 64'(bus.src1_ready), 64'd1);
    send1(ADD, 32'h33);
    check("add_accepted", 64'(bus.src1_ready), 64'd0);
    send2(32'h44);
    tick();
    check("after_mult_a", 64'(bus.op_a), 64'h33);
    check("after_mult_b", 64'(bus.op_b), 64'h44);
    tick();
    // fill the FIFO with the unit stalled, then hold a fifth pair
    bus.op_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send_both(32'(k), 32'(k + 'h100));
      tick();
    end
    check("fill_cnt", 64'(bus.fifo_count), 64'd4);
    check("fill_full", 64'(bus.fifo_full), 64'd1);
    send_both(32'd5, 32'h105);
    tick();
    check("full_cnt", 64'(bus.fifo_count), 64'd4);
    check("full_rdy1", 64'(bus.src1_ready), 64'd0);
    check("full_rdy2", 64'(bus.src2_ready), 64'd0);
    bus.op_ready = 1'b1;
    check("head_a1", 64'(bus.op_a), 64'd1);
    tick();
    check("pushpop_cnt", 64'(bus.fifo_count), 64'd4);
    check("pushpop_rdy1", 64'(bus.src1_ready), 64'd1);
    for (int k = 2; k <= 5; k++) begin
      check("order_a", 64'(bus.op_a), 64'(k));
      check("order_b", 64'(bus.op_b), 64'(k + 'h100));
      tick();
    end
    check("drain_cnt", 64'(bus.fifo_count), 64'd0);
    check("drain_valid", 64'(bus.op_valid), 64'd0);
    // both operands in the same cycle
    bus.op_ready = 1'b0;
    send_both(32'hAAAA, 32'h5555);
    check("same_novalid", 64'(bus.op_valid), 64'd0);
    tick();
    check("same_valid", 64'(bus.op_valid), 64'd1);
    check("same_a", 64'(bus.op_a), 64'hAAAA);
    check("same_b", 64'(bus.op_b), 64'h5555);
    bus.op_ready = 1'b1;
    tick();
    check("same_drain", 64'(bus.fifo_count), 64'd0);
    // reset with three queued pairs and a held src1
    bus.op_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_both(32'(k + 'h20), 32'(k + 'h30));
      tick();
    end
    send1(ADD, 32'hDEAD);
    check("pre_rst_cnt", 64'(bus.fifo_count), 64'd3);
    check("pre_rst_rdy1", 64'(bus.src1_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_cnt", 64'(bus.fifo_count), 64'd0);
    check("mid_rst_valid", 64'(bus.op_valid), 64'd0);
    check("mid_rst_rdy1", 64'(bus.src1_ready), 64'd1);
    check("mid_rst_rdy2", 64'(bus.src2_ready), 64'd1);
    send_both(32'h77, 32'h88);
    tick();
    check("post_rst_a", 64'(bus.op_a), 64'h77);
    check("post_rst_b", 64'(bus.op_b), 64'h88);
    check("post_rst_cnt", 64'(bus.fifo_count), 64'd1);
`ifdef COLLECTOR_STATS_EN
    check("stall_zero", 64'(bus.stall_count), 64'd0);
    for (int k = 0; k < 3; k++) begin
      send_both(32'(k), 32'(k));
      tick();
    end
    send_both(32'h1, 32'h2);
    for (int k = 0; k < 10; k++) tick();
    check("stall_ten", 64'(bus.stall_count), 64'd10);
    bus.op_ready = 1'b1;
    tick();
    check("stall_hold", 64'(bus.stall_count), 64'd10);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
